// File: rtl/mux_lut_gate_pkg.sv
// Shared definitions for the mux-built LUT gate: preset opcodes, the serial
// configuration FSM state type and the preset truth-table generator.
package mux_gate_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_BUF  = 3'd6;
   localparam logic [2:0] OP_NOT  = 3'd7;

   localparam int MAX_K    = 6;
   localparam int MAX_TT_W = 1 << MAX_K;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} cfg_state_e;

   // Returns the table at full 64-bit width; callers cast down to 2^k bits.
   // Bit i is the gate output when the input vector equals i.
   function automatic logic [MAX_TT_W-1:0] preset_tt(input logic [2:0] op, input int k);
      logic [MAX_TT_W-1:0] t;
      logic [5:0]          idx;
      int                  tt_w;
      t    = '0;
      tt_w = 1 << k;
      for (int i = 0; i < MAX_TT_W; i++) begin
         idx = 6'(i);
         if (i < tt_w) begin
            case (op)
               OP_AND:  t[i] = (i == tt_w - 1);
               OP_OR:   t[i] = (i != 0);
               OP_NAND: t[i] = (i != tt_w - 1);
               OP_NOR:  t[i] = (i == 0);
               OP_XOR:  t[i] = ^idx;
               OP_XNOR: t[i] = ~^idx;
               OP_BUF:  t[i] = idx[0];
               OP_NOT:  t[i] = ~idx[0];
               default: t[i] = 1'b0;
            endcase
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/mux_lut_gate_if.sv
// Bus bundle for the LUT gate.
//   master: drives x, op_load, op, cfg_start, cfg_valid, cfg_bit;
//           observes cfg_busy, cfg_done, tt, y.
//   slave : the gate itself.
interface mux_lut_gate_if #(parameter int K = 2) ();
   localparam int TT_W = 1 << K;

   logic [K-1:0]    x;
   logic            op_load;
   logic [2:0]      op;
   logic            cfg_start;
   logic            cfg_valid;
   logic            cfg_bit;
   logic            cfg_busy;
   logic            cfg_done;
   logic [TT_W-1:0] tt;
   logic            y;

   modport master (
      output x, op_load, op, cfg_start, cfg_valid, cfg_bit,
      input  cfg_busy, cfg_done, tt, y
   );

   modport slave (
      input  x, op_load, op, cfg_start, cfg_valid, cfg_bit,
      output cfg_busy, cfg_done, tt, y
   );
endinterface

// File: rtl/mux_lut_gate_mux_tree.sv
// Recursive 2:1 mux tree selecting tt[sel].
//   tt  : 2^K-bit truth table
//   sel : K-bit index (sel[0] = LSB, resolved at the leaves)
//   y   : selected table bit
module mux_tree #(
   parameter int K = 2
) (
   input  logic [(1<<K)-1:0] tt,
   input  logic [K-1:0]      sel,
   output logic              y
);
   generate
      if (K == 1) begin : g_leaf
         assign y = sel[0] ? tt[1] : tt[0];
      end else begin : g_node
         localparam int HALF = 1 << (K - 1);
         logic y_lo;
         logic y_hi;

         mux_tree #(.K(K-1)) u_lo (
            .tt  (tt[HALF-1:0]),
            .sel (sel[K-2:0]),
            .y   (y_lo)
         );

         mux_tree #(.K(K-1)) u_hi (
            .tt  (tt[2*HALF-1:HALF]),
            .sel (sel[K-2:0]),
            .y   (y_hi)
         );

         assign y = sel[K-1] ? y_hi : y_lo;
      end
   endgenerate
endmodule

// File: rtl/mux_lut_gate.sv
// Reconfigurable K-input gate: y = tt[x], with tt set by a preset opcode or
// a bit-serial load that commits atomically.
//   clk, rst : rising-edge clock, async active-high reset
//   bus      : slave side of mux_lut_gate_if (x, op/op_load, cfg_* serial
//              load handshake, tt observation, y)
//
// state  | meaning
// IDLE   | tt live; accepts op_load or cfg_start
// SHIFT  | collecting serial bits into shadow; tt untouched
// COMMIT | shadow copied to tt at the next edge; cfg_done high
module mux_lut_gate
   import mux_gate_pkg::*;
#(
   parameter int K       = 2,
   parameter bit REG_OUT = 1'b1
) (
   input logic           clk,
   input logic           rst,
   mux_lut_gate_if.slave bus
);
   localparam int TT_W  = 1 << K;
   // One spare bit so the counter never wraps before the terminal compare.
   localparam int CNT_W = $clog2(TT_W) + 1;
   localparam logic [TT_W-1:0] TT_RST = TT_W'(preset_tt(OP_OR, K));

   cfg_state_e       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [TT_W-1:0]  shadow_q, shadow_d;
   logic [TT_W-1:0]  tt_q,     tt_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             tree_y;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      tt_d     = tt_q;
      case (state_q)
         IDLE: begin
            // cfg_start has priority; a coincident op_load is dropped.
            if (bus.cfg_start) begin
               state_d  = SHIFT;
               cnt_d    = '0;
               shadow_d = '0;
            end else if (bus.op_load) begin
               tt_d = TT_W'(preset_tt(bus.op, K));
            end
         end
         SHIFT: begin
            if (bus.cfg_start) begin
               // Restart; the beat in this cycle is discarded.
               cnt_d    = '0;
               shadow_d = '0;
            end else if (bus.cfg_valid) begin
               for (int i = 0; i < TT_W; i++) begin
                  if (cnt_q == CNT_W'(i)) shadow_d[i] = bus.cfg_bit;
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(TT_W - 1)) state_d = COMMIT;
            end
         end
         COMMIT: begin
            tt_d    = shadow_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == COMMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         tt_q     <= TT_RST;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         tt_q     <= tt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   mux_tree #(.K(K)) u_tree (
      .tt  (tt_q),
      .sel (bus.x),
      .y   (tree_y)
   );

   generate
      if (REG_OUT) begin : g_reg_out
         logic y_q;
         logic y_d;
         assign y_d = tree_y;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) y_q <= 1'b0;
            else     y_q <= y_d;
         end
         assign bus.y = y_q;
      end else begin : g_comb_out
         assign bus.y = tree_y;
      end
   endgenerate

   assign bus.tt       = tt_q;
   assign bus.cfg_busy = busy_q;
   assign bus.cfg_done = done_q;
endmodule

// File: tb/tb_mux_lut_gate.sv
module tb_mux_lut_gate;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_lut_gate_if #(.K(2)) bus_a ();
   mux_lut_gate_if #(.K(3)) bus_b ();

   mux_lut_gate #(.K(2), .REG_OUT(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   mux_lut_gate #(.K(3), .REG_OUT(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       op_load;
      logic [2:0] op;
      logic [1:0] x;
      logic [3:0] tt;
      logic       y;
   } vec_t;

   typedef struct {
      logic [3:0] tt;
      logic       y;
   } exp_t;

   vec_t vecs[20];
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One clock on dut_a with the given serial-load inputs, then check outputs.
   task automatic step_a(input logic st, input logic v, input logic b, input logic ol,
                         input logic eb, input logic ed, input logic [3:0] ett,
                         input logic ey, input string name);
      bus_a.cfg_start = st;
      bus_a.cfg_valid = v;
      bus_a.cfg_bit   = b;
      bus_a.op_load   = ol;
      cyc();
      bus_a.cfg_start = 1'b0;
      bus_a.cfg_valid = 1'b0;
      bus_a.op_load   = 1'b0;
      chk({name, "_busy"}, 8'(bus_a.cfg_busy), 8'(eb));
      chk({name, "_done"}, 8'(bus_a.cfg_done), 8'(ed));
      chk({name, "_tt"},   8'(bus_a.tt),       8'(ett));
      chk({name, "_y"},    8'(bus_a.y),        8'(ey));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      exp_t       e;
      logic [7:0] pat;

      // {op_load, op, x, tt after edge, y after edge (old tt[x])}
      vecs[0]  = '{1'b0, 3'd0, 2'd0, 4'b1110, 1'b0};
      vecs[1]  = '{1'b0, 3'd0, 2'd1, 4'b1110, 1'b1};
      vecs[2]  = '{1'b0, 3'd0, 2'd3, 4'b1110, 1'b1};
      vecs[3]  = '{1'b1, 3'd4, 2'd2, 4'b0110, 1'b1};
      vecs[4]  = '{1'b0, 3'd0, 2'd3, 4'b0110, 1'b0};
      vecs[5]  = '{1'b0, 3'd0, 2'd2, 4'b0110, 1'b1};
      vecs[6]  = '{1'b1, 3'd5, 2'd0, 4'b1001, 1'b0};
      vecs[7]  = '{1'b0, 3'd0, 2'd0, 4'b1001, 1'b1};
      vecs[8]  = '{1'b1, 3'd6, 2'd1, 4'b1010, 1'b0};
      vecs[9]  = '{1'b0, 3'd0, 2'd1, 4'b1010, 1'b1};
      vecs[10] = '{1'b1, 3'd7, 2'd1, 4'b0101, 1'b1};
      vecs[11] = '{1'b0, 3'd0, 2'd1, 4'b0101, 1'b0};
      vecs[12] = '{1'b1, 3'd2, 2'd3, 4'b0111, 1'b0};
      vecs[13] = '{1'b0, 3'd0, 2'd3, 4'b0111, 1'b0};
      vecs[14] = '{1'b1, 3'd3, 2'd0, 4'b0001, 1'b1};
      vecs[15] = '{1'b0, 3'd0, 2'd0, 4'b0001, 1'b1};
      vecs[16] = '{1'b1, 3'd0, 2'd3, 4'b1000, 1'b0};
      vecs[17] = '{1'b0, 3'd0, 2'd3, 4'b1000, 1'b1};
      vecs[18] = '{1'b1, 3'd4, 2'd1, 4'b0110, 1'b0};
      vecs[19] = '{1'b0, 3'd0, 2'd1, 4'b0110, 1'b1};

      rst = 1'b1;
      bus_a.x = '0; bus_a.op_load = 1'b0; bus_a.op = '0;
      bus_a.cfg_start = 1'b0; bus_a.cfg_valid = 1'b0; bus_a.cfg_bit = 1'b0;
      bus_b.x = '0; bus_b.op_load = 1'b0; bus_b.op = '0;
      bus_b.cfg_start = 1'b0; bus_b.cfg_valid = 1'b0; bus_b.cfg_bit = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_tt_a",   8'(bus_a.tt),       8'h0E);
      chk("rst_busy_a", 8'(bus_a.cfg_busy), 8'h00);
      chk("rst_done_a", 8'(bus_a.cfg_done), 8'h00);
      chk("rst_y_a",    8'(bus_a.y),        8'h00);
      chk("rst_tt_b",   8'(bus_b.tt),       8'hFE);
      rst = 1'b0;

      // Table-driven presets and y lookups through the scoreboard.
      for (int i = 0; i < 20; i++) begin
         bus_a.op_load = vecs[i].op_load;
         bus_a.op      = vecs[i].op;
         bus_a.x       = vecs[i].x;
         exp_q.push_back('{vecs[i].tt, vecs[i].y});
         cyc();
         bus_a.op_load = 1'b0;
         e = exp_q.pop_front();
         chk($sformatf("vec%0d_tt", i), 8'(bus_a.tt), 8'(e.tt));
         chk($sformatf("vec%0d_y", i),  8'(bus_a.y),  8'(e.y));
      end

      // Serial load 1,0,0,1 with a stall gap and an ignored op_load (AND).
      bus_a.x  = 2'd3;
      bus_a.op = 3'd0;
      step_a(1, 0, 0, 0, 1, 0, 4'b0110, 0, "ld1_start");
      step_a(0, 1, 1, 0, 1, 0, 4'b0110, 0, "ld1_b0");
      step_a(0, 1, 0, 0, 1, 0, 4'b0110, 0, "ld1_b1");
      step_a(0, 0, 0, 1, 1, 0, 4'b0110, 0, "ld1_gap_opload");
      step_a(0, 0, 0, 0, 1, 0, 4'b0110, 0, "ld1_gap");
      step_a(0, 1, 0, 0, 1, 0, 4'b0110, 0, "ld1_b2");
      step_a(0, 1, 1, 0, 1, 1, 4'b0110, 0, "ld1_commit");
      step_a(0, 0, 0, 0, 0, 0, 4'b1001, 0, "ld1_new_tt");
      step_a(0, 0, 0, 0, 0, 0, 4'b1001, 1, "ld1_new_y");

      // Restart mid-load: the coincident beat is discarded, then 0,1,1,0.
      step_a(1, 0, 0, 0, 1, 0, 4'b1001, 1, "rs_start");
      step_a(0, 1, 1, 0, 1, 0, 4'b1001, 1, "rs_b0");
      step_a(1, 1, 1, 0, 1, 0, 4'b1001, 1, "rs_restart");
      step_a(0, 1, 0, 0, 1, 0, 4'b1001, 1, "rs_n0");
      step_a(0, 1, 1, 0, 1, 0, 4'b1001, 1, "rs_n1");
      step_a(0, 1, 1, 0, 1, 0, 4'b1001, 1, "rs_n2");
      step_a(0, 1, 0, 0, 1, 1, 4'b1001, 1, "rs_commit");
      step_a(0, 0, 0, 0, 0, 0, 4'b0110, 1, "rs_new_tt");
      step_a(0, 0, 0, 0, 0, 0, 4'b0110, 0, "rs_new_y");

      // cfg_start with op_load in IDLE: start wins; then reset mid-SHIFT.
      step_a(1, 0, 0, 1, 1, 0, 4'b0110, 0, "sim_start");
      step_a(0, 1, 1, 0, 1, 0, 4'b0110, 0, "ab_b0");
      step_a(0, 1, 1, 0, 1, 0, 4'b0110, 0, "ab_b1");
      rst = 1'b1;
      #1;
      chk("abort_busy", 8'(bus_a.cfg_busy), 8'h00);
      chk("abort_done", 8'(bus_a.cfg_done), 8'h00);
      chk("abort_tt",   8'(bus_a.tt),       8'h0E);
      chk("abort_y",    8'(bus_a.y),        8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Full load after abort: 0,0,0,1 -> AND.
      step_a(1, 0, 0, 0, 1, 0, 4'b1110, 1, "re_start");
      step_a(0, 1, 0, 0, 1, 0, 4'b1110, 1, "re_b0");
      step_a(0, 1, 0, 0, 1, 0, 4'b1110, 1, "re_b1");
      step_a(0, 1, 0, 0, 1, 0, 4'b1110, 1, "re_b2");
      step_a(0, 1, 1, 0, 1, 1, 4'b1110, 1, "re_commit");
      step_a(0, 0, 0, 0, 0, 0, 4'b1000, 1, "re_new_tt");
      bus_a.x = 2'd2;
      step_a(0, 0, 0, 0, 0, 0, 4'b1000, 0, "re_x2");

      // K=3, combinational output.
      chk("b_rst_tt", 8'(bus_b.tt), 8'hFE);
      bus_b.op = 3'd0; bus_b.op_load = 1'b1;
      cyc();
      bus_b.op_load = 1'b0;
      chk("b_and_tt", 8'(bus_b.tt), 8'h80);
      bus_b.x = 3'b111; #1;
      chk("b_and_y7", 8'(bus_b.y), 8'h01);
      bus_b.x = 3'b110; #1;
      chk("b_and_y6", 8'(bus_b.y), 8'h00);
      bus_b.op = 3'd4; bus_b.op_load = 1'b1;
      @(negedge clk);
      cyc();
      bus_b.op_load = 1'b0;
      chk("b_xor_tt", 8'(bus_b.tt), 8'h96);
      bus_b.x = 3'd3; #1;
      chk("b_xor_y3", 8'(bus_b.y), 8'h00);
      bus_b.x = 3'd4; #1;
      chk("b_xor_y4", 8'(bus_b.y), 8'h01);

      @(negedge clk);
      bus_b.cfg_start = 1'b1; bus_b.op_load = 1'b1; bus_b.op = 3'd1;
      cyc();
      bus_b.cfg_start = 1'b0; bus_b.op_load = 1'b0;
      chk("b_sim_busy", 8'(bus_b.cfg_busy), 8'h01);
      chk("b_sim_tt",   8'(bus_b.tt),       8'h96);
      pat = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         bus_b.cfg_valid = 1'b1;
         bus_b.cfg_bit   = pat[i];
         cyc();
         chk($sformatf("b_ld%0d_busy", i), 8'(bus_b.cfg_busy), 8'h01);
         chk($sformatf("b_ld%0d_done", i), 8'(bus_b.cfg_done), (i == 7) ? 8'h01 : 8'h00);
         chk($sformatf("b_ld%0d_tt", i),   8'(bus_b.tt),       8'h96);
      end
      bus_b.cfg_valid = 1'b0;
      cyc();
      chk("b_ld_tt",   8'(bus_b.tt),       8'h5A);
      chk("b_ld_busy", 8'(bus_b.cfg_busy), 8'h00);
      chk("b_ld_done", 8'(bus_b.cfg_done), 8'h00);
      bus_b.x = 3'd1; #1;
      chk("b_ld_y1", 8'(bus_b.y), 8'h01);
      bus_b.x = 3'd0; #1;
      chk("b_ld_y0", 8'(bus_b.y), 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
